// File: rtl/ps2_paddle_rx.sv
// PS/2 keyboard receiver for a two-player paddle game: filters the PS/2 clock,
// deframes 11-bit frames and decodes W/S and extended Up/Down make/break codes.
module ps2_paddle_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up1,
  output logic       down1,
  output logic       up2,
  output logic       down2,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN + 1)  : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_fcnt;
  logic [1:0]    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bcnt;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic          r_ext, r_brk;
  logic          r_up1, r_down1, r_up2, r_down2;
  logic [7:0]    r_code;
  logic          r_valid, r_err;
  logic          w_fall;
  logic          w_good;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // r_fcnt counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FCNT_MAX) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;
  assign w_good = r_dat_s2 & (^{r_shift, r_par});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_par   <= 1'b0;
      r_tcnt  <= '0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_up1   <= 1'b0;
      r_down1 <= 1'b0;
      r_up2   <= 1'b0;
      r_down2 <= 1'b0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_fall || r_state == S_IDLE) r_tcnt <= '0;
      else                             r_tcnt <= r_tcnt + TW'(1);

      if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            r_bcnt <= '0;
            if (!r_dat_s2) r_state <= S_DATA;
          end
          S_DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            r_bcnt  <= r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (w_good) begin
              r_code  <= r_shift;
              r_valid <= 1'b1;
              if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
              end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
              end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                // Non-extended 75/72 are keypad keys and fall through unmapped.
                if (!r_ext && r_shift == 8'h1D) r_up1   <= !r_brk;
                if (!r_ext && r_shift == 8'h1B) r_down1 <= !r_brk;
                if ( r_ext && r_shift == 8'h75) r_up2   <= !r_brk;
                if ( r_ext && r_shift == 8'h72) r_down2 <= !r_brk;
              end
            end else begin
              r_err <= 1'b1;
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end
          end
        endcase
      end else if (r_state != S_IDLE && r_tcnt == TCNT_MAX) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
        r_ext   <= 1'b0;
        r_brk   <= 1'b0;
      end
    end
  end

  assign up1        = r_up1;
  assign down1      = r_down1;
  assign up2        = r_up2;
  assign down2      = r_down2;
  assign scan_code  = r_code;
  assign scan_valid = r_valid;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_ps2_paddle_rx.sv
// Bench for ps2_paddle_rx: bit-banged PS/2 frames, queued expected bytes popped on scan_valid.
module tb_ps2_paddle_rx;
  localparam int H  = 40;
  localparam int TO = 2000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up1, down1, up2, down2, scan_valid, frame_err;
  logic [7:0] scan_code;

  int         checks = 0, errors = 0, n_valid = 0, n_err = 0;
  logic [7:0] q[$];
  logic [7:0] exp_code = 8'h00;
  logic [7:0] sb_exp;
  logic       prev_valid = 1'b0;

  ps2_paddle_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up1(up1), .down1(down1), .up2(up2), .down2(down2),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (scan_valid) begin
        n_valid++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h want no byte", scan_code);
        end else begin
          sb_exp = q.pop_front();
          if (scan_code !== sb_exp) begin
            errors++;
            $display("FAIL sb_byte: got %h want %h", scan_code, sb_exp);
          end
        end
      end
      if (frame_err) n_err++;
      if (scan_valid || frame_err) begin
        checks++;
        if (scan_valid && frame_err) begin
          errors++;
          $display("FAIL valid_err_overlap: got both high want exclusive");
        end
        if (scan_valid && prev_valid) begin
          errors++;
          $display("FAIL valid_width: got 2-cycle pulse want 1");
        end
      end
    end
    prev_valid = scan_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      cyc(10); ps2_clk = 1'b0; cyc(4); ps2_clk = 1'b1; cyc(H - 14);
    end else begin
      cyc(H);
    end
    ps2_clk = 1'b0;
    cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, input logic glitch);
    logic par;
    par = (~^b) ^ bad_par;
    if (!bad_par && !bad_stop) begin
      q.push_back(b);
      exp_code = b;
    end
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(!bad_stop, glitch);
    ps2_data = 1'b1;
    cyc(2 * H);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic check_sb(input string tag);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d queued want 0", tag, q.size());
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cyc(5);
    checks++;
    if ({up1, down1, up2, down2, scan_valid, frame_err, scan_code} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 0",
               {up1, down1, up2, down2, scan_valid, frame_err, scan_code});
    end
    reset_n = 1'b1;
    cyc(20);
  endtask

  task automatic test_make_break;
    int v0;
    v0 = n_valid;
    good(8'h1D);
    checks++;
    if (up1 !== 1'b1 || n_valid - v0 != 1 || scan_code !== 8'h1D) begin
      errors++;
      $display("FAIL make_1d: got up1=%b pulses=%0d code=%h want 1 1 1d", up1, n_valid - v0, scan_code);
    end
    v0 = n_valid;
    good(8'hF0); good(8'h1D);
    checks++;
    if (up1 !== 1'b0 || n_valid - v0 != 2) begin
      errors++;
      $display("FAIL break_1d: got up1=%b pulses=%0d want 0 2", up1, n_valid - v0);
    end
    check_sb("make_break");
  endtask

  task automatic test_extended;
    good(8'hE0); good(8'h75); good(8'h1B);
    checks++;
    if ({up1, down1, up2, down2} !== 4'b0110) begin
      errors++;
      $display("FAIL ext_make: got %b want 0110", {up1, down1, up2, down2});
    end
    good(8'hE0); good(8'hF0); good(8'h75);
    checks++;
    if ({up1, down1, up2, down2} !== 4'b0100) begin
      errors++;
      $display("FAIL ext_break: got %b want 0100", {up1, down1, up2, down2});
    end
    good(8'h75);
    checks++;
    if (up2 !== 1'b0) begin
      errors++;
      $display("FAIL keypad_75: got up2=%b want 0", up2);
    end
    good(8'h1D);
    checks++;
    if ({up1, down1} !== 2'b11) begin
      errors++;
      $display("FAIL opposing: got %b want 11", {up1, down1});
    end
    good(8'hF0); good(8'h1D); good(8'h1B);
    checks++;
    if ({up1, down1} !== 2'b01 || scan_code !== 8'h1B) begin
      errors++;
      $display("FAIL typematic: got %b code=%h want 01 1b", {up1, down1}, scan_code);
    end
    check_sb("extended");
  endtask

  task automatic test_parity_err;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1D, 1'b1, 1'b0, 1'b0);
    checks++;
    if (n_err - e0 != 1 || n_valid != v0 || up1 !== 1'b0 || scan_code !== exp_code) begin
      errors++;
      $display("FAIL parity_err: got err=%0d val=%0d up1=%b code=%h want 1 0 0 %h",
               n_err - e0, n_valid - v0, up1, scan_code, exp_code);
    end
  endtask

  task automatic test_stop_err;
    int e0;
    e0 = n_err;
    send_frame(8'h1D, 1'b0, 1'b1, 1'b0);
    checks++;
    if (n_err - e0 != 1 || up1 !== 1'b0) begin
      errors++;
      $display("FAIL stop_err: got err=%0d up1=%b want 1 0", n_err - e0, up1);
    end
    e0 = n_err;
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    good(8'h1D);
    checks++;
    if (n_err - e0 != 1 || up1 !== 1'b1) begin
      errors++;
      $display("FAIL brk_cleared: got err=%0d up1=%b want 1 1", n_err - e0, up1);
    end
    good(8'hE0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    good(8'h75);
    checks++;
    if (up2 !== 1'b0) begin
      errors++;
      $display("FAIL ext_cleared: got up2=%b want 0", up2);
    end
    good(8'hF0); good(8'h1D); good(8'hF0); good(8'h1B);
    checks++;
    if ({up1, down1, up2, down2} !== 4'b0000) begin
      errors++;
      $display("FAIL release_all: got %b want 0000", {up1, down1, up2, down2});
    end
    check_sb("stop_err");
  endtask

  task automatic test_timeout;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_partial(8'h1D, 5);
    cyc(TO + 200);
    checks++;
    if (n_err - e0 != 1 || n_valid != v0) begin
      errors++;
      $display("FAIL timeout_err: got err=%0d val=%0d want 1 0", n_err - e0, n_valid - v0);
    end
    cyc(TO + 200);
    checks++;
    if (n_err - e0 != 1) begin
      errors++;
      $display("FAIL timeout_once: got err=%0d want 1", n_err - e0);
    end
    good(8'h1B);
    checks++;
    if (down1 !== 1'b1 || scan_code !== 8'h1B || n_valid - v0 != 1) begin
      errors++;
      $display("FAIL after_timeout: got down1=%b code=%h val=%0d want 1 1b 1",
               down1, scan_code, n_valid - v0);
    end
    check_sb("timeout");
  endtask

  task automatic test_glitch_reset;
    send_frame(8'h1D, 1'b0, 1'b0, 1'b1);
    checks++;
    if (up1 !== 1'b1 || scan_code !== 8'h1D) begin
      errors++;
      $display("FAIL glitch: got up1=%b code=%h want 1 1d", up1, scan_code);
    end
    send_partial(8'h1B, 3);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({up1, down1, up2, down2, scan_valid, frame_err, scan_code} !== 14'h0) begin
      errors++;
      $display("FAIL reset_mid: got %b want 0",
               {up1, down1, up2, down2, scan_valid, frame_err, scan_code});
    end
    cyc(3);
    reset_n = 1'b1;
    cyc(20);
    good(8'h1B);
    checks++;
    if ({up1, down1, up2, down2} !== 4'b0100 || scan_code !== 8'h1B) begin
      errors++;
      $display("FAIL after_reset: got %b code=%h want 0100 1b", {up1, down1, up2, down2}, scan_code);
    end
    check_sb("glitch_reset");
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    good(8'hE0); good(8'h72);
    checks++;
    if (down2 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_down2: got %b want 1", down2);
    end
    good(8'h72); good(8'hE0); good(8'hF0); good(8'h72); good(8'hF0); good(8'h1B);
    checks++;
    if ({up1, down1, up2, down2} !== 4'b0000 || n_valid - v0 != 8) begin
      errors++;
      $display("FAIL b2b_final: got %b val=%0d want 0000 8", {up1, down1, up2, down2}, n_valid - v0);
    end
    check_sb("back_to_back");
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_glitch_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_paddle_rx.md
PS2_PADDLE_RX -- requirements
Module: ps2_paddle_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required to accept a level change.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000: clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned (200 us at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port ps2_clk  input  1  PS/2 keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  PS/2 keyboard data, asynchronous to clk.
REQ-007 SHALL have port up1  output  1  level; high while key W (0x1D) is held.
REQ-008 SHALL have port down1  output  1  level; high while key S (0x1B) is held.
REQ-009 SHALL have port up2  output  1  level; high while extended Up arrow (E0 75) is held.
REQ-010 SHALL have port down2  output  1  level; high while extended Down arrow (E0 72) is held.
REQ-011 SHALL have port scan_code  output  8  last correctly received byte, held until the next one.
REQ-012 SHALL have port scan_valid  output  1  one-cycle pulse when scan_code is updated.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers each before any use.
REQ-015 SHALL change the filtered ps2_clk only after FILTER_LEN consecutive equal synchronized samples; a falling edge is filtered 1->0; pulses shorter than FILTER_LEN are ignored.
REQ-016 SHALL sample synchronized ps2_data on each filtered falling edge, using FSM states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: data 0 -> DATA with bit count 0; data 1 -> stay in IDLE, no error.
REQ-018 DATA: shift bits LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: capture the bit -> STOP; the 8 data bits plus the parity bit SHALL contain an odd number of ones.
REQ-020 STOP: stop bit 1 and parity good -> byte accepted; otherwise frame_err; either way -> IDLE.
REQ-021 Accepted byte SHALL update scan_code with scan_valid high exactly 1 clk after the cycle in which the stop-bit edge is detected; key outputs SHALL update in that same cycle.
REQ-022 Timeout counter SHALL reset on every filtered falling edge; reaching TIMEOUT_CYC outside IDLE -> IDLE plus frame_err; it SHALL not count in IDLE.
REQ-023 Decoder: byte E0 sets ext_flag; byte F0 sets brk_flag; both flags are consumed (cleared) by the next non-prefix byte.
REQ-024 Non-prefix byte SHALL be matched against the key table with ext_flag: mapped output <= !brk_flag; unmapped codes leave every output unchanged.
REQ-025 W/S SHALL match only with ext_flag=0; Up/Down only with ext_flag=1 (non-extended 75/72 are keypad keys, ignored).
REQ-026 Errored frames SHALL clear ext_flag and brk_flag and leave key outputs unchanged.
REQ-027 Opposing keys held together SHALL both read high; arbitration belongs to Paddle.
REQ-028 Typematic repeat makes SHALL keep the output high, with no toggling.
REQ-029 scan_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-030 While reset_n=0: FSM in IDLE, shift register, bit count, timeout counter, filter state 1, flags 0.
REQ-031 While reset_n=0: all outputs are 0, scan_code is 0x00, and the filtered ps2_clk is 1.
REQ-032 Deassertion mid-frame SHALL restart cleanly: partial bits are discarded and the next start bit begins a new frame.

Verification
REQ-033 Send 1D (parity 1, stop 1) at 12.5 kHz -> scan_code=0x1D, one scan_valid pulse, up1=1; then F0 1D -> up1=0, two scan_valid pulses.
REQ-034 Send E0 75, then 1B -> up2=1, down1=1, up1=0 and down2=0; then E0 F0 75 -> up2=0, down1 still 1.
REQ-035 Send 1D with a corrupted parity bit -> frame_err pulse, no scan_valid, up1 stays 0, scan_code unchanged.
REQ-036 Send 1D with stop bit 0 -> frame_err; then F0 with parity error followed by a good 1D -> brk_flag cleared, up1=1.
REQ-037 Stop after 5 data bits for more than TIMEOUT_CYC -> frame_err exactly once, FSM in IDLE; the next full 1B frame is decoded correctly.
REQ-038 Inject 4-cycle low glitches on ps2_clk mid-frame -> decoded byte unaffected; assert reset_n=0 mid-frame -> all outputs 0 immediately; the following frame decodes correctly.
